// File: rtl/sram_req_adapter_pkg.sv
// Shared types and constants for the SRAM request adapter and its response FIFO.
package sram_req_adapter_pkg;

  localparam int DATA_W    = 64;
  localparam int BEN_W     = 8;
  localparam int RSP_DEPTH = 2;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              wr;
    logic              err;
  } rsp_entry_t;

  // Writes and address errors carry no read data back to the requester.
  function automatic rsp_entry_t make_rsp(logic [DATA_W-1:0] rd_data, logic wr, logic err);
    rsp_entry_t e;
    e.data = (wr || err) ? '0 : rd_data;
    e.wr   = wr;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/sram_req_adapter_if.sv
// Request/response bundle of the SRAM request adapter (valid/ready on both channels).
// Handshake: a beat transfers on a rising edge where valid and ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface sram_req_adapter_if
  import sram_req_adapter_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wr_en;
  logic [BEN_W-1:0]      req_ben;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_W-1:0]     req_wr_data;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rd_data;
  logic                  rsp_wr;
  logic                  rsp_err;

  modport master (
    output req_valid, req_wr_en, req_ben, req_addr, req_wr_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_data, rsp_wr, rsp_err
  );

  modport slave (
    input  req_valid, req_wr_en, req_ben, req_addr, req_wr_data, rsp_ready,
    output req_ready, rsp_valid, rsp_rd_data, rsp_wr, rsp_err
  );

endinterface

// File: rtl/sram_req_adapter_rsp_fifo.sv
// Two-entry response FIFO; push and pop may happen in the same cycle.
module sram_rsp_fifo
  import sram_req_adapter_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  rsp_entry_t       i_push_entry,
  input  logic             i_pop,
  output rsp_entry_t       o_head,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(RSP_DEPTH);

  rsp_entry_t       r_mem [RSP_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL) || w_pop);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/sram_req_adapter.sv
// Valid/ready front end for a 1-cycle-latency SRAM with an in-order 2-entry response buffer.
// Optional address bounds check: define SRAM_REQ_ADAPTER_BOUNDS_CHK_EN.
module sram_req_adapter
  import sram_req_adapter_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,

  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrEn_SI,
  input  logic [BEN_W-1:0]      ReqBEn_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [DATA_W-1:0]     ReqWrData_DI,

  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic [DATA_W-1:0]     RspRdData_DO,
  output logic                  RspWr_SO,
  output logic                  RspErr_SO,

  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [BEN_W-1:0]      BEn_SO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  output logic [DATA_W-1:0]     WrData_DO,
  input  logic [DATA_W-1:0]     RdData_DI
);

  if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DATA_DEPTH must not exceed 2**ADDR_WIDTH");
  end

  logic             r_inflight;
  logic             r_if_wr;
  logic             r_if_err;

  logic             w_accept;
  logic             w_addr_ok;
  logic             w_pop;
  logic [2:0]       w_credit;
  logic [CNT_W-1:0] w_fifo_count;
  rsp_entry_t       w_push_entry;
  rsp_entry_t       w_head;

`ifdef SRAM_REQ_ADAPTER_BOUNDS_CHK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DATA_DEPTH);
  assign w_addr_ok = ({1'b0, ReqAddr_DI} < DEPTH_L);
`else
  assign w_addr_ok = 1'b1;
`endif

  // Outstanding = in flight + buffered; a same-cycle pop frees a slot for this cycle's accept.
  assign w_pop       = RspValid_SO && RspReady_SI;
  assign w_credit    = {2'b00, r_inflight} + {1'b0, w_fifo_count} - {2'b00, w_pop};
  assign ReqReady_SO = !Rst_RI && (w_credit < 3'd2);
  assign w_accept    = ReqValid_SI && ReqReady_SO;

  assign CSel_SO   = w_accept && w_addr_ok;
  assign WrEn_SO   = CSel_SO && ReqWrEn_SI;
  assign BEn_SO    = CSel_SO ? ReqBEn_SI : '0;
  assign Addr_DO   = Rst_RI ? '0 : ReqAddr_DI;
  assign WrData_DO = Rst_RI ? '0 : ReqWrData_DI;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_inflight <= 1'b0;
      r_if_wr    <= 1'b0;
      r_if_err   <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_if_wr  <= ReqWrEn_SI;
        r_if_err <= !w_addr_ok;
      end
    end
  end

  assign w_push_entry = make_rsp(RdData_DI, r_if_wr, r_if_err);

  sram_rsp_fifo u_rsp_fifo (
    .i_clk        (Clk_CI),
    .i_rst        (Rst_RI),
    .i_push       (r_inflight),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_count      (w_fifo_count)
  );

  // Without the bounds check the stored err bit is always 0, so RspErr_SO stays 0.
  assign RspValid_SO  = !Rst_RI && (w_fifo_count != '0);
  assign RspRdData_DO = RspValid_SO ? w_head.data : '0;
  assign RspWr_SO     = RspValid_SO && w_head.wr;
  assign RspErr_SO    = RspValid_SO && w_head.err;

endmodule

// File: tb/tb_sram_req_adapter.sv
// Randomized scoreboard bench for sram_req_adapter with a transaction-level reference model.
module tb_sram_req_adapter;
  import sram_req_adapter_pkg::*;

  localparam int AW    = 10;
  localparam int DEPTH = 1000;
  localparam int MEMW  = 1 << AW;

`ifdef SRAM_REQ_ADAPTER_BOUNDS_CHK_EN
  localparam bit BOUNDS_ON = 1'b1;
`else
  localparam bit BOUNDS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_req_adapter_if #(.ADDR_WIDTH(AW)) bus ();

  logic          csel, wren;
  logic [7:0]    ben;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic [63:0]   rdata = '0;

  sram_req_adapter #(.ADDR_WIDTH(AW), .DATA_DEPTH(DEPTH)) dut (
    .Clk_CI       (clk),
    .Rst_RI       (rst),
    .ReqValid_SI  (bus.req_valid),
    .ReqReady_SO  (bus.req_ready),
    .ReqWrEn_SI   (bus.req_wr_en),
    .ReqBEn_SI    (bus.req_ben),
    .ReqAddr_DI   (bus.req_addr),
    .ReqWrData_DI (bus.req_wr_data),
    .RspValid_SO  (bus.rsp_valid),
    .RspReady_SI  (bus.rsp_ready),
    .RspRdData_DO (bus.rsp_rd_data),
    .RspWr_SO     (bus.rsp_wr),
    .RspErr_SO    (bus.rsp_err),
    .CSel_SO      (csel),
    .WrEn_SO      (wren),
    .BEn_SO       (ben),
    .Addr_DO      (addr),
    .WrData_DO    (wdata),
    .RdData_DI    (rdata)
  );

  // SRAM attached to the RAM side: registered read, byte-enabled write.
  logic [63:0] ram [MEMW];
  always @(posedge clk) begin
    if (csel) begin
      if (wren) begin
        for (int b = 0; b < 8; b++)
          if (ben[b]) ram[addr][8*b +: 8] <= wdata[8*b +: 8];
      end else begin
        rdata <= ram[addr];
      end
    end
  end

  // ---------------- reference model ----------------
  logic [63:0] ref_mem [MEMW];

  function automatic logic [65:0] model_req(logic wr, logic [AW-1:0] a, logic [7:0] be,
                                            logic [63:0] d);
    logic err;
    err = BOUNDS_ON && (int'(a) >= DEPTH);
    if (err) return {64'd0, wr, 1'b1};
    if (wr) begin
      for (int b = 0; b < 8; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      return {64'd0, 1'b1, 1'b0};
    end
    return {ref_mem[a], 1'b0, 1'b0};
  endfunction

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q [$];
  int          avail_q [$];
  int          cyc      = 0;
  int          n_vec    = 0;
  int          n_fail   = 0;
  bit          acc_flag = 1'b0;
  int          run      = 0;
  int          max_run  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit exp_valid, exp_pop, exp_ready, exp_acc, exp_csel, in_range;
    cyc++;
    if (rst) begin
      exp_q.delete();
      avail_q.delete();
      acc_flag = 1'b0;
      run      = 0;
      check("reset_ctrl", {bus.req_ready, bus.rsp_valid, bus.rsp_wr, bus.rsp_err,
                           csel, wren, ben, addr}, '0);
      check("reset_data", {bus.rsp_rd_data, wdata}, '0);
    end else begin
      exp_valid = (exp_q.size() > 0) && (avail_q[0] <= cyc);
      exp_pop   = exp_valid && bus.rsp_ready;
      exp_ready = (int'(exp_q.size()) - int'(exp_pop)) < 2;
      check("rsp_valid", bus.rsp_valid, exp_valid);
      check("req_ready", bus.req_ready, exp_ready);
      if (exp_pop) begin
        check("rsp_payload", {bus.rsp_rd_data, bus.rsp_wr, bus.rsp_err}, exp_q[0]);
        void'(exp_q.pop_front());
        void'(avail_q.pop_front());
      end
      exp_acc  = bus.req_valid && exp_ready;
      in_range = !BOUNDS_ON || (int'(bus.req_addr) < DEPTH);
      exp_csel = exp_acc && in_range;
      check("ram_side", {csel, wren, ben, addr, wdata},
            {exp_csel, exp_csel && bus.req_wr_en, exp_csel ? bus.req_ben : 8'h00,
             bus.req_addr, bus.req_wr_data});
      if (exp_acc) begin
        exp_q.push_back(model_req(bus.req_wr_en, bus.req_addr, bus.req_ben, bus.req_wr_data));
        avail_q.push_back(cyc + 2);
      end
      acc_flag = exp_acc;
      run      = bus.rsp_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.req_valid   = 1'b0;
    bus.req_wr_en   = 1'b0;
    bus.req_ben     = '0;
    bus.req_addr    = '0;
    bus.req_wr_data = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [AW-1:0] a, input logic [7:0] be,
                           input logic [63:0] d);
    bus.req_valid   = 1'b1;
    bus.req_wr_en   = wr;
    bus.req_ben     = be;
    bus.req_addr    = a;
    bus.req_wr_data = d;
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [7:0] be,
                       input logic [63:0] d, input bit rand_rdy);
    drive_req(wr, a, be, d);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (acc_flag) begin
        bus.req_valid = 1'b0;
        return;
      end
      if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    n_vec++;
    n_fail++;
    $display("FAIL issue_timeout: request addr %0d never accepted", a);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) wait_cycles(1);
    wait_cycles(2);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < MEMW; i++) begin
      ram[i]     = {$urandom, $urandom};
      ref_mem[i] = ram[i];
    end
    ram[5]     = 64'h1122334455667788;
    ref_mem[5] = 64'h1122334455667788;
    ram[3]     = '0;
    ref_mem[3] = '0;

    drive_idle();
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    wait_cycles(2);

    // single read and write-then-read
    bus.rsp_ready = 1'b1;
    issue(1'b0, 10'd5, 8'h00, 64'd0, 1'b0);
    wait_cycles(4);
    issue(1'b1, 10'd3, 8'h0F, 64'hFFFF_0000_FFFF_0000, 1'b0);
    issue(1'b0, 10'd3, 8'h00, 64'd0, 1'b0);
    wait_cycles(4);

    // back-pressure: two accepted, third held off until the consumer resumes
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'd10, 8'h00, 64'd0, 1'b0);
    issue(1'b0, 10'd11, 8'h00, 64'd0, 1'b0);
    drive_req(1'b0, 10'd12, 8'h00, 64'd0);
    wait_cycles(6);
    check("bp_outstanding", exp_q.size(), 2);
    bus.rsp_ready = 1'b1;
    issue(1'b0, 10'd12, 8'h00, 64'd0, 1'b0);
    issue(1'b0, 10'd13, 8'h00, 64'd0, 1'b0);
    drive_idle();
    drain();

    // streaming
    run     = 0;
    max_run = 0;
    for (int i = 0; i < 100; i++)
      issue(1'b0, AW'($urandom_range(0, DEPTH - 1)), 8'h00, 64'd0, 1'b0);
    drive_idle();
    wait_cycles(5);
    check("stream_run", max_run, 100);

    // bounds edge
    issue(1'b0, 10'd999, 8'h00, 64'd0, 1'b0);
    issue(1'b0, 10'd1000, 8'h00, 64'd0, 1'b0);
    issue(1'b1, 10'd1010, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0);
    issue(1'b0, 10'd1010, 8'h00, 64'd0, 1'b0);
    drive_idle();
    drain();

    // reset with two responses buffered
    bus.rsp_ready = 1'b0;
    issue(1'b0, 10'd20, 8'h00, 64'd0, 1'b0);
    issue(1'b0, 10'd21, 8'h00, 64'd0, 1'b0);
    drive_idle();
    wait_cycles(3);
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_cycles(6);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, MEMW - 1)),
            8'($urandom_range(0, 255)), {$urandom, $urandom}, 1'b1);
      drive_idle();
      repeat ($urandom_range(0, 2)) begin
        bus.rsp_ready = ($urandom_range(0, 1) != 0);
        wait_cycles(1);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
